mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_port_arbiter_rr_pick2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types, defaults and helpers for mem_port_arbiter  | Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int GCNT_W      = 16;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  function automatic logic [GCNT_W-1:0] sat_inc(input logic [GCNT_W-1:0] v);
    return (v == {GCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
// ============================================================================
// rr_pick2 : combinational two-way pick; prio breaks a tie          | Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 && req1) ? prio : (req1 ? REQ_DATA : REQ_FETCH);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : fetch/data port arbiter onto one memory; grant counters
// only with MEM_ARB_STATS_EN defined                                 | Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [GCNT_W-1:0] gcnt0,
  output logic [GCNT_W-1:0] gcnt1
);

  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT out of range");
  end

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                pick_valid;
  logic                pick_win;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .prio   (prio_q),
    .valid  (pick_valid),
    .winner (pick_win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      prio_q   <= REQ_FETCH;
      owner_q  <= REQ_FETCH;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          // The pointer moves to the loser so a held request wins next time.
          owner_d = pick_win;
          prio_d  = ~pick_win;
          we_d    = pick_win ? we1    : we0;
          addr_d  = pick_win ? addr1  : addr0;
          wdata_d = pick_win ? wdata1 : wdata0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = we_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          if (owner_q == REQ_DATA) rdata1_d = mem_rdata;
          else                     rdata0_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt0      = (state_q == ISSUE) && (owner_q == REQ_FETCH);
  assign gnt1      = (state_q == ISSUE) && (owner_q == REQ_DATA);
  assign rvalid0   = (state_q == RESP)  && (owner_q == REQ_FETCH);
  assign rvalid1   = (state_q == RESP)  && (owner_q == REQ_DATA);
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

`ifdef MEM_ARB_STATS_EN
  logic [GCNT_W-1:0] gcnt0_q, gcnt1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (gnt0) gcnt0_q <= sat_inc(gcnt0_q);
      if (gnt1) gcnt1_q <= sat_inc(gcnt1_q);
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
`else
  assign gcnt0 = '0;
  assign gcnt1 = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : scoreboard bench, MEM_LAT=1 main instance plus a
// MEM_LAT=4 instance                                                 | Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
`ifdef MEM_ARB_STATS_EN
  localparam int EXP_G0 = 3;
`else
  localparam int EXP_G0 = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, mem_addr;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, rdata0, rdata1, mem_wdata, mem_rdata;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy, owner;
  logic [15:0]   gcnt0, gcnt1;

  logic          l4_req0 = 0, l4_we0 = 0;
  logic [AW-1:0] l4_addr0 = '0, l4_mem_addr;
  logic [DW-1:0] l4_rdata0, l4_rdata1, l4_mem_wdata, l4_mem_rdata;
  logic          l4_gnt0, l4_gnt1, l4_rvalid0, l4_rvalid1, l4_mem_en, l4_mem_we, l4_busy, l4_owner;
  logic [15:0]   l4_gcnt0, l4_gcnt1;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner), .gcnt0(gcnt0), .gcnt1(gcnt1)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(4)) u_dut_l4 (
    .clk(clk), .reset(reset),
    .req0(l4_req0), .req1(1'b0), .we0(l4_we0), .we1(1'b0),
    .addr0(l4_addr0), .addr1(8'h00), .wdata0(16'h0000), .wdata1(16'h0000),
    .gnt0(l4_gnt0), .gnt1(l4_gnt1), .rvalid0(l4_rvalid0), .rvalid1(l4_rvalid1),
    .rdata0(l4_rdata0), .rdata1(l4_rdata1),
    .mem_en(l4_mem_en), .mem_we(l4_mem_we), .mem_addr(l4_mem_addr), .mem_wdata(l4_mem_wdata),
    .mem_rdata(l4_mem_rdata), .busy(l4_busy), .owner(l4_owner), .gcnt0(l4_gcnt0), .gcnt1(l4_gcnt1)
  );

  // Memory model: preset words plus anything written; read data appears
  // only for the exact latency cycle, so an early or late capture reads 0.
  logic [255:0]  wvalid = '0;
  logic [DW-1:0] wmem [256];
  logic [DW-1:0] p1 = '0;
  logic [DW-1:0] p4 [4] = '{default: '0};

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (wvalid[a]) return wmem[a];
    case (a)
      8'h10:   return 16'hA5A5;
      8'h11:   return 16'h1111;
      8'h12:   return 16'h2222;
      8'h30:   return 16'h0C0C;
      8'h31:   return 16'h3131;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wmem[mem_addr]   <= mem_wdata;
      wvalid[mem_addr] <= 1'b1;
    end
    p1    <= (mem_en && !mem_we) ? mem_rd(mem_addr) : '0;
    p4[0] <= (l4_mem_en && !l4_mem_we) ? mem_rd(l4_mem_addr) : '0;
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    p4[3] <= p4[2];
  end
  assign mem_rdata    = p1;
  assign l4_mem_rdata = p4[3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rv_count = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            rv;
    int            port;
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic mon(input int inst, input logic g0, g1, v0, v1, input logic [DW-1:0] rd0, rd1,
                     input logic en, we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic o);
    exp_t e;
    chk("mem_en_vs_gnt", en, g0 | g1);
    if (!en) chk("mem_we_idle", we, 1'b0);
    if (g0 | g1) begin
      chk("gnt_exclusive", g0 & g1, 1'b0);
      if ((inst == 0 ? q0.size() : q1.size()) == 0) flag("unexpected_gnt");
      else begin
        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
        chk("gnt_kind", e.rv, 1'b0);
        chk("gnt_port", g1, e.port);
        chk("gnt_cycle", cyc, e.cyc);
        chk("mem_we", we, e.we);
        chk("mem_addr", a, e.addr);
        if (e.we) chk("mem_wdata", wd, e.data);
        chk("owner", o, e.port);
      end
    end
    if (v0 | v1) begin
      rv_count++;
      chk("rvalid_exclusive", v0 & v1, 1'b0);
      if ((inst == 0 ? q0.size() : q1.size()) == 0) flag("unexpected_rvalid");
      else begin
        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
        chk("rv_kind", e.rv, 1'b1);
        chk("rv_port", v1, e.port);
        chk("rv_cycle", cyc, e.cyc);
        chk("rdata", v1 ? rd1 : rd0, e.data);
      end
    end
  endtask

  always @(negedge clk)
    mon(0, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata, owner);
  always @(negedge clk)
    mon(1, l4_gnt0, l4_gnt1, l4_rvalid0, l4_rvalid1, l4_rdata0, l4_rdata1,
        l4_mem_en, l4_mem_we, l4_mem_addr, l4_mem_wdata, l4_owner);

  task automatic wait_idle();
    for (int i = 0; i < 12; i++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    flag("idle_timeout");
  endtask

  // One arbitration round on the MEM_LAT=1 instance; win/rdexp are hand-derived.
  task automatic step(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input int win, input logic [DW-1:0] rdexp);
    exp_t e;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    e.rv = 0; e.port = win; e.cyc = cyc + 1;
    e.we = win ? w1 : w0; e.addr = win ? a1 : a0; e.data = win ? d1 : d0;
    q0.push_back(e);
    if (!e.we) begin
      e.rv = 1; e.cyc = cyc + 3; e.data = rdexp;
      q0.push_back(e);
    end
    @(posedge clk); #1;
    if (win == 0) req0 = 0; else req1 = 0;
    wait_idle();
    req0 = 0; req1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int bcnt;
    int rvs;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", {gnt0, gnt1}, 2'b00);
    chk("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
    chk("rst_mem_strobe", {mem_en, mem_we}, 2'b00);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_rdata0", rdata0, 16'h0000);
    chk("rst_owner", owner, 1'b0);
    chk("rst_gcnt", {gcnt0, gcnt1}, 32'h0);
    reset = 1;
    @(posedge clk); #1;

    // Conflict after reset: 0,1,0,1
    step(1, 0, 8'h10, 16'h0, 1, 0, 8'h30, 16'h0, 0, 16'hA5A5);
    step(1, 0, 8'h11, 16'h0, 1, 0, 8'h30, 16'h0, 1, 16'h0C0C);
    step(1, 0, 8'h11, 16'h0, 1, 0, 8'h31, 16'h0, 0, 16'h1111);
    step(1, 0, 8'h12, 16'h0, 1, 0, 8'h31, 16'h0, 1, 16'h3131);
    // Single read, then write and read-back on the data port (prio at 0)
    step(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0, 0, 16'hA5A5);
    step(0, 0, 8'h00, 16'h0, 1, 1, 8'h20, 16'h1234, 1, 16'h0);
    chk("mem_addr_hold", mem_addr, 8'h20);
    chk("mem_wdata_hold", mem_wdata, 16'h1234);
    step(0, 0, 8'h00, 16'h0, 1, 0, 8'h20, 16'h0, 1, 16'h1234);
    step(1, 0, 8'h11, 16'h0, 0, 0, 8'h00, 16'h0, 0, 16'h1111);
    chk("rdata1_held", rdata1, 16'h1234);

    // MEM_LAT=4: rvalid 6 cycles after sampling, busy for 6 cycles
    l4_req0 = 1; l4_we0 = 0; l4_addr0 = 8'h10;
    e.rv = 0; e.port = 0; e.cyc = cyc + 1; e.we = 0; e.addr = 8'h10; e.data = 16'h0;
    q1.push_back(e);
    e.rv = 1; e.cyc = cyc + 6; e.data = 16'hA5A5;
    q1.push_back(e);
    @(posedge clk); #1;
    l4_req0 = 0;
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (l4_busy) bcnt++;
      @(posedge clk); #1;
    end
    chk("l4_busy_cycles", bcnt, 6);

    // Reset in WAIT discards the read
    req0 = 1; we0 = 0; addr0 = 8'h11;
    e.rv = 0; e.port = 0; e.cyc = cyc + 1; e.we = 0; e.addr = 8'h11; e.data = 16'h0;
    q0.push_back(e);
    @(posedge clk); #1;
    req0 = 0;
    @(posedge clk); #1;
    chk("in_wait_busy", busy, 1'b1);
    reset = 0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_strobes", {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we}, 6'b0);
    chk("mid_rst_mem_addr", mem_addr, 8'h00);
    chk("mid_rst_mem_wdata", mem_wdata, 16'h0000);
    chk("mid_rst_rdata0", rdata0, 16'h0000);
    chk("mid_rst_rdata1", rdata1, 16'h0000);
    rvs = rv_count;
    @(posedge clk); #1;
    reset = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_rvalid_after_reset", rv_count, rvs);

    // Three port-0 grants for the statistics counters
    step(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0, 0, 16'hA5A5);
    step(1, 1, 8'h40, 16'h5555, 0, 0, 8'h00, 16'h0, 0, 16'h0);
    step(1, 0, 8'h40, 16'h0, 0, 0, 8'h00, 16'h0, 0, 16'h5555);
    chk("gcnt0", gcnt0, EXP_G0);
    chk("gcnt1", gcnt1, 16'h0000);

    repeat (4) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
